// File: rtl/instr_packer_pkg.sv
// rtl/instr_packer_pkg.sv - format/state encodings, field positions and packing function
package instr_packer_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_RSV = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam int INST_W   = 16;
  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 13;
  localparam int RS_HI    = 12;
  localparam int RS_LO    = 10;
  localparam int RT_HI    = 9;
  localparam int RT_LO    = 7;
  localparam int RD_HI    = 6;
  localparam int RD_LO    = 4;
  localparam int FUNCT_HI = 3;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 6;
  localparam int IMM_LO   = 0;
  localparam int ADDR_HI  = 12;
  localparam int ADDR_LO  = 0;

  // Anything that is not R or I (including the reserved tag) packs as J.
  function automatic logic [INST_W-1:0] pack_word(
    input logic [1:0]  fmt,
    input logic [2:0]  opcode,
    input logic [2:0]  rs,
    input logic [2:0]  rt,
    input logic [2:0]  rd,
    input logic [3:0]  funct,
    input logic [6:0]  imm_val,
    input logic [12:0] address
  );
    logic [INST_W-1:0] w;
    w = '0;
    w[OPC_HI:OPC_LO] = opcode;
    case (fmt)
      FMT_R: begin
        w[RS_HI:RS_LO]       = rs;
        w[RT_HI:RT_LO]       = rt;
        w[RD_HI:RD_LO]       = rd;
        w[FUNCT_HI:FUNCT_LO] = funct;
      end
      FMT_I: begin
        w[RS_HI:RS_LO]   = rs;
        w[RT_HI:RT_LO]   = rt;
        w[IMM_HI:IMM_LO] = imm_val;
      end
      default: w[ADDR_HI:ADDR_LO] = address;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_packer_fifo.sv
// rtl/instr_packer_fifo.sv - instr_fifo: synchronous packed-word FIFO, async active-low reset
module instr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign full   = (r_cnt == DEPTH[PW:0]);
  assign empty  = (r_cnt == '0);
  assign head   = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= push_data;
  end

endmodule

// File: rtl/instr_packer.sv
// rtl/instr_packer.sv - packs decoded fields into 16-bit words and streams them to imem.
// Optional PACKER_FMT_CHECK_EN: drop reserved-format tuples and flag err.
module instr_packer
  import instr_packer_pkg::*;
#(
  parameter int inst_SIZE  = 16,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    word_count,
  input  logic                 fld_valid,
  output logic                 fld_ready,
  input  logic [1:0]           fld_fmt,
  input  logic [2:0]           opcode,
  input  logic [2:0]           rs,
  input  logic [2:0]           rt,
  input  logic [2:0]           rd,
  input  logic [3:0]           funct,
  input  logic [6:0]           imm_val,
  input  logic [12:0]          address,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [inst_SIZE-1:0] imem_wdata,
  input  logic                 imem_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e                r_state;
  state_e                w_next;
  logic [ADDR_W-1:0]     r_addr;
  logic [ADDR_W-1:0]     r_count;
  logic [ADDR_W-1:0]     r_accepted;
  logic                  w_start;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [inst_SIZE-1:0]  w_head;
  logic [inst_SIZE-1:0]  w_packed;

  assign w_start  = (r_state == IDLE) & start;
  assign w_accept = fld_valid & fld_ready;
  assign w_pop    = imem_we & imem_ready;
  assign w_packed = inst_SIZE'(pack_word(fld_fmt, opcode, rs, rt, rd, funct, imm_val, address));

`ifdef PACKER_FMT_CHECK_EN
  logic w_rsv;
  logic r_err;
  assign w_rsv  = (fld_fmt == FMT_RSV);
  assign w_push = w_accept & ~w_rsv;
  assign err    = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_err <= 1'b0;
    else if (w_start)          r_err <= 1'b0;
    else if (w_accept & w_rsv) r_err <= 1'b1;
  end
`else
  assign w_push = w_accept;
  assign err    = 1'b0;
`endif

  instr_fifo #(
    .WIDTH (inst_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_packed),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = (word_count == '0) ? DONE : LOAD;
      LOAD:  if (r_accepted == r_count) w_next = DRAIN;
      DRAIN: if (w_fifo_empty) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    fld_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      IDLE:  busy = 1'b0;
      LOAD:  fld_ready = ~w_fifo_full & (r_accepted < r_count);
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_count    <= '0;
      r_accepted <= '0;
    end else if (w_start) begin
      r_addr     <= base_addr;
      r_count    <= word_count;
      r_accepted <= '0;
    end else begin
      if (w_pop)  r_addr     <= r_addr + ADDR_W'(1);
      if (w_push) r_accepted <= r_accepted + ADDR_W'(1);
    end
  end

  // Head is gated so the write bus reads zero whenever nothing is queued.
  assign imem_we    = ~w_fifo_empty;
  assign imem_addr  = r_addr;
  assign imem_wdata = imem_we ? w_head : '0;

endmodule

// File: tb/tb_instr_packer.sv
// tb/tb_instr_packer.sv - directed self-checking bench for instr_packer
module tb_instr_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  word_count;
  logic        fld_valid;
  logic        fld_ready;
  logic [1:0]  fld_fmt;
  logic [2:0]  opcode, rs, rt, rd;
  logic [3:0]  funct;
  logic [6:0]  imm_val;
  logic [12:0] address;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        imem_ready;
  logic        busy, done, err;

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  int done_base;
  int wr_base;
  int idx;
  logic w_rdy;
  logic [7:0]  wa_q[$];
  logic [15:0] wd_q[$];

  always #5 clk = ~clk;

  instr_packer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .fld_valid(fld_valid), .fld_ready(fld_ready),
    .fld_fmt(fld_fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .funct(funct), .imm_val(imm_val), .address(address),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .busy(busy), .done(done), .err(err)
  );

  // Inputs change 1ns after posedge, so the negedge view is stable up to the next edge.
  always @(negedge clk) begin
    if (rst_n && imem_we && imem_ready) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
    end
    if (done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int k, input logic [7:0] a, input logic [15:0] d);
    logic [7:0]  oa;
    logic [15:0] od;
    oa = (wr_base + k < wa_q.size()) ? wa_q[wr_base + k] : 8'hxx;
    od = (wr_base + k < wd_q.size()) ? wd_q[wr_base + k] : 16'hxxxx;
    chk({tag, "_addr"}, {24'h0, oa}, {24'h0, a});
    chk({tag, "_data"}, {16'h0, od}, {16'h0, d});
  endtask

  task automatic set_fld(input logic [1:0] f, input logic [2:0] op, input logic [2:0] a,
                         input logic [2:0] b, input logic [2:0] c, input logic [3:0] fn,
                         input logic [6:0] im, input logic [12:0] ad);
    fld_fmt = f; opcode = op; rs = a; rt = b; rd = c; funct = fn; imm_val = im; address = ad;
  endtask

  task automatic send(input string tag);
    logic ok;
    ok = 1'b0;
    fld_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ok = fld_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    fld_valid = 1'b0;
    chk({tag, "_accept"}, {31'h0, ok}, 32'h1);
  endtask

  task automatic start_sess(input logic [7:0] b, input logic [7:0] c);
    wr_base   = wa_q.size();
    done_base = n_done;
    start = 1'b1; base_addr = b; word_count = c;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk({tag, "_idle"}, {31'h0, ok}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    fld_valid = 1'b0; imem_ready = 1'b1;
    set_fld(2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 7'd0, 13'd0);

    @(negedge clk);
    chk("rst_fld_ready", {31'h0, fld_ready}, 0);
    chk("rst_imem_we", {31'h0, imem_we}, 0);
    chk("rst_imem_addr", {24'h0, imem_addr}, 0);
    chk("rst_imem_wdata", {16'h0, imem_wdata}, 0);
    chk("rst_busy_done_err", {29'h0, busy, done, err}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single R word
    start_sess(8'h10, 8'd1);
    @(negedge clk);
    chk("r_busy_k1", {31'h0, busy}, 1);
    chk("r_ready_k1", {31'h0, fld_ready}, 1);
    @(posedge clk); #1;
    set_fld(2'b00, 3'd0, 3'd1, 3'd2, 3'd3, 4'd2, 7'd0, 13'd0);
    send("r_tuple");
    @(negedge clk);
    chk("r_latency_we", {31'h0, imem_we}, 1);
    chk("r_latency_wdata", {16'h0, imem_wdata}, 32'h0532);
    wait_idle("r");
    chk("r_nwrites", wa_q.size() - wr_base, 1);
    chk_wr("r_w0", 0, 8'h10, 16'h0532);
    chk("r_done_pulses", n_done - done_base, 1);
    chk("r_busy_after", {31'h0, busy}, 0);

    // Zero-length session
    start_sess(8'h30, 8'd0);
    @(negedge clk);
    chk("z_done_busy", {30'h0, done, busy}, 32'h3);
    @(negedge clk);
    chk("z_after", {30'h0, done, busy}, 0);
    chk("z_nwrites", wa_q.size() - wr_base, 0);
    @(posedge clk); #1;

    // I then J
    start_sess(8'h20, 8'd2);
    set_fld(2'b01, 3'd4, 3'd2, 3'd5, 3'd0, 4'd0, 7'h7F, 13'd0);
    send("ij_i");
    set_fld(2'b10, 3'd7, 3'd0, 3'd0, 3'd0, 4'd0, 7'd0, 13'h0ABC);
    send("ij_j");
    wait_idle("ij");
    chk("ij_nwrites", wa_q.size() - wr_base, 2);
    chk_wr("ij_w0", 0, 8'h20, 16'h8AFF);
    chk_wr("ij_w1", 1, 8'h21, 16'hEABC);

    // Backpressure: memory stalls for 10 cycles with a continuous tuple stream
    imem_ready = 1'b0;
    start_sess(8'h40, 8'd6);
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      set_fld(2'b00, 3'd1, 3'd0, 3'd0, 3'd0, idx[3:0], 7'd0, 13'd0);
      fld_valid = 1'b1;
      @(negedge clk); w_rdy = fld_ready;
      @(posedge clk); #1;
      if (w_rdy) idx++;
    end
    chk("bp_accepts_full", idx, 4);
    chk("bp_ready_low", {31'h0, fld_ready}, 0);
    chk("bp_hold", {7'h0, imem_we, imem_addr, imem_wdata}, {7'h0, 1'b1, 8'h40, 16'h2000});
    imem_ready = 1'b1;
    for (int c = 0; c < 30 && idx < 6; c++) begin
      set_fld(2'b00, 3'd1, 3'd0, 3'd0, 3'd0, idx[3:0], 7'd0, 13'd0);
      fld_valid = 1'b1;
      @(negedge clk); w_rdy = fld_ready;
      @(posedge clk); #1;
      if (w_rdy) idx++;
    end
    fld_valid = 1'b0;
    chk("bp_accepts_all", idx, 6);
    wait_idle("bp");
    chk("bp_nwrites", wa_q.size() - wr_base, 6);
    for (int k = 0; k < 6; k++)
      chk_wr("bp_w", k, 8'h40 + 8'(k), 16'h2000 + 16'(k));
    chk("bp_done_pulses", n_done - done_base, 1);

    // Address wrap
    start_sess(8'hFE, 8'd3);
    for (int k = 1; k <= 3; k++) begin
      set_fld(2'b10, 3'd7, 3'd0, 3'd0, 3'd0, 4'd0, 7'd0, 13'(k));
      send("wrap_tuple");
    end
    wait_idle("wrap");
    chk("wrap_nwrites", wa_q.size() - wr_base, 3);
    chk_wr("wrap_w0", 0, 8'hFE, 16'hE001);
    chk_wr("wrap_w1", 1, 8'hFF, 16'hE002);
    chk_wr("wrap_w2", 2, 8'h00, 16'hE003);

    // Reserved format tag
    start_sess(8'h70, 8'd2);
    set_fld(2'b11, 3'd5, 3'd0, 3'd0, 3'd0, 4'd0, 7'd0, 13'h0123);
    send("rsv_t0");
    set_fld(2'b00, 3'd0, 3'd1, 3'd2, 3'd3, 4'd2, 7'd0, 13'd0);
    send("rsv_t1");
`ifdef PACKER_FMT_CHECK_EN
    set_fld(2'b00, 3'd1, 3'd0, 3'd0, 3'd0, 4'd1, 7'd0, 13'd0);
    send("rsv_t2");
    wait_idle("rsv");
    chk("rsv_nwrites", wa_q.size() - wr_base, 2);
    chk_wr("rsv_w0", 0, 8'h70, 16'h0532);
    chk_wr("rsv_w1", 1, 8'h71, 16'h2001);
    chk("rsv_err", {31'h0, err}, 1);
`else
    wait_idle("rsv");
    chk("rsv_nwrites", wa_q.size() - wr_base, 2);
    chk_wr("rsv_w0", 0, 8'h70, 16'hA123);
    chk_wr("rsv_w1", 1, 8'h71, 16'h0532);
    chk("rsv_err", {31'h0, err}, 0);
    chk("rsv_ready_after", {31'h0, fld_ready}, 0);
`endif

    // Reset in DRAIN with three words queued
    imem_ready = 1'b0;
    start_sess(8'h50, 8'd3);
    for (int k = 0; k < 3; k++) begin
      set_fld(2'b00, 3'd2, 3'd0, 3'd0, 3'd0, 4'(k), 7'd0, 13'd0);
      send("drn_tuple");
    end
    @(posedge clk); #1;
    chk("drn_pre_busy_we", {30'h0, busy, imem_we}, 32'h3);
    rst_n = 1'b0;
    #1;
    chk("drn_rst_ready_we", {30'h0, fld_ready, imem_we}, 0);
    chk("drn_rst_addr", {24'h0, imem_addr}, 0);
    chk("drn_rst_wdata", {16'h0, imem_wdata}, 0);
    chk("drn_rst_busy_done_err", {29'h0, busy, done, err}, 0);
    imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("drn_no_writes", wa_q.size() - wr_base, 0);
    start_sess(8'h60, 8'd1);
    set_fld(2'b00, 3'd0, 3'd1, 3'd2, 3'd3, 4'd2, 7'd0, 13'd0);
    send("post_tuple");
    wait_idle("post");
    chk("post_nwrites", wa_q.size() - wr_base, 1);
    chk_wr("post_w0", 0, 8'h60, 16'h0532);
    chk("post_done_pulses", n_done - done_base, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
